// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: FSM states and length encoding.
// CKSUM state exists only with PROG_LOADER_CKSUM_EN.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
`ifdef PROG_LOADER_CKSUM_EN
    ST_CKSUM = 3'd3,
`endif
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam bit LEN_ZERO_IS_256 = 1'b1;

  function automatic logic [8:0] len_of(input logic [7:0] b);
    if (b == 8'd0 && LEN_ZERO_IS_256)
      return 9'd256;
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inactivity timer for prog_loader; expired after TIMEOUT enabled
// cycles without a clear.
module prog_loader_timer
  import prog_loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] r_cnt;
  logic        w_hit;

  assign w_hit   = (r_cnt == TIMEOUT - 16'd1);
  assign expired = enable && w_hit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (enable && !w_hit)
      r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: LEN, DATA into RAM, optional CKSUM
// (PROG_LOADER_CKSUM_EN), then a run pulse to the stage sequencer.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_wren,
  output logic       cpu_halt,
  output logic       cpu_run,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e      r_state;
  state_e      w_next;
  logic [8:0]  r_left;
  logic [7:0]  r_idx;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_wren;
  logic        r_done;
  logic        r_err;
  logic        w_rx;
  logic        w_acc;
  logic        w_halt;
  logic        w_wr;
  logic        w_expired;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  w_ck;
  assign w_ck = r_sum + rx_data;
  assign w_rx = (r_state == ST_LEN) ||
                (r_state == ST_DATA) ||
                (r_state == ST_CKSUM);
`else
  assign w_rx = (r_state == ST_LEN) ||
                (r_state == ST_DATA);
`endif

  assign w_acc = rx_valid && w_rx;

  prog_loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .clrn   (clrn),
    .clear  (w_acc || !w_rx),
    .enable (w_rx),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // timeout wins over any byte accepted in the same cycle
  always_comb begin
    w_next = r_state;
    w_halt = 1'b0;
    w_wr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start)
          w_next = ST_LEN;
      end
      ST_LEN: begin
        w_halt = 1'b1;
        if (w_expired)
          w_next = ST_ERR;
        else if (w_acc)
          w_next = ST_DATA;
      end
      ST_DATA: begin
        w_halt = 1'b1;
        if (w_expired) begin
          w_next = ST_ERR;
        end else if (w_acc) begin
          w_wr = 1'b1;
          if (r_left == 9'd1)
`ifdef PROG_LOADER_CKSUM_EN
            w_next = ST_CKSUM;
`else
            w_next = ST_RUN;
`endif
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        w_halt = 1'b1;
        if (w_expired)
          w_next = ST_ERR;
        else if (w_acc)
          w_next = (w_ck == 8'd0) ? ST_RUN : ST_ERR;
      end
`endif
      ST_RUN: begin
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_halt = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_left  <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_wren <= w_wr;
      if (r_state == ST_IDLE && start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_idx  <= '0;
        r_left <= '0;
`ifdef PROG_LOADER_CKSUM_EN
        r_sum  <= '0;
`endif
      end
      if (r_state == ST_LEN && w_acc && !w_expired)
        r_left <= len_of(rx_data);
      if (w_wr) begin
        r_addr  <= BASE_ADDR + r_idx;
        r_wdata <= rx_data;
        r_idx   <= r_idx + 8'd1;
        r_left  <= r_left - 9'd1;
`ifdef PROG_LOADER_CKSUM_EN
        r_sum   <= r_sum + rx_data;
`endif
      end
      if (r_state == ST_RUN)
        r_done <= 1'b1;
      if (w_next == ST_ERR)
        r_err <= 1'b1;
    end
  end

  assign rx_ready  = w_rx;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_wren  = r_wren;
  assign cpu_halt  = w_halt;
  assign cpu_run   = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 00 and FE)
// share one byte stream; both use a 16-cycle inactivity limit.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       rdy_a, wren_a, halt_a, run_a, busy_a, done_a, err_a;
  logic [7:0] addr_a, wd_a;
  logic       rdy_b, wren_b, halt_b, run_b, busy_b, done_b, err_b;
  logic [7:0] addr_b, wd_b;

  always #5 clk = ~clk;

  prog_loader #(
    .BASE_ADDR(8'h00),
    .TIMEOUT  (16'd16)
  ) u_a (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rdy_a),
    .ram_addr (addr_a),
    .ram_wdata(wd_a),
    .ram_wren (wren_a),
    .cpu_halt (halt_a),
    .cpu_run  (run_a),
    .busy     (busy_a),
    .done     (done_a),
    .err      (err_a)
  );

  prog_loader #(
    .BASE_ADDR(8'hFE),
    .TIMEOUT  (16'd16)
  ) u_b (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rdy_b),
    .ram_addr (addr_b),
    .ram_wdata(wd_b),
    .ram_wren (wren_b),
    .cpu_halt (halt_b),
    .cpu_run  (run_b),
    .busy     (busy_b),
    .done     (done_b),
    .err      (err_b)
  );

  int total = 0;
  int bad = 0;
  int runs = 0;
  int wrs = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always @(negedge clk) begin
    if (wren_a) begin
      qa.push_back({addr_a, wd_a});
      wrs++;
    end
    if (wren_b)
      qb.push_back({addr_b, wd_b});
    if (run_a)
      runs++;
  end

  function automatic logic [22:0] outs_a();
    return {rdy_a, wren_a, addr_a, wd_a,
            halt_a, run_a, busy_a, done_a, err_a};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go();
    qa.delete();
    qb.delete();
    runs = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rdy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdy", {31'd0, rdy_a}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle", {31'd0, busy_a}, 32'd0);
  endtask

  logic [15:0] e1a[3] = '{16'h0011, 16'h0122, 16'h0233};
  logic [15:0] e1b[3] = '{16'hFE11, 16'hFF22, 16'h0033};

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int errs;
    repeat (3) @(negedge clk);
    chk("rst_outs", {9'd0, outs_a()}, 32'd0);
    clrn = 1'b1;

    // basic load, base 00 and base FE
    go();
    chk("t1_busy", {busy_a, halt_a, done_a, err_a}, 4'b1100);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
`ifdef PROG_LOADER_CKSUM_EN
    send(8'h9A);
`endif
    wait_idle();
    chk("t1_runs", runs, 1);
    chk("t1_flags", {done_a, err_a, halt_a}, 3'b100);
    chk("t1_na", qa.size(), 3);
    chk("t1_nb", qb.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_wa", qa[i], e1a[i]);
      chk("t1_wb", qb[i], e1b[i]);
    end

`ifdef PROG_LOADER_CKSUM_EN
    // bad checksum
    go();
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h9B);
    chk("t2_err", {err_a, halt_a, done_a, run_a}, 4'b1100);
    @(negedge clk);
    chk("t2_idle", {busy_a, err_a, halt_a, done_a}, 4'b0100);
    chk("t2_runs", runs, 0);
`endif

    // length 0 means 256 bytes
    go();
    send(8'h00);
    for (int i = 0; i < 256; i++)
      send(i[7:0]);
`ifdef PROG_LOADER_CKSUM_EN
    chk("t3_ck", {rdy_a, busy_a, run_a}, 3'b110);
    send(8'h80);
`else
    chk("t3_run", {rdy_a, run_a}, 2'b01);
`endif
    wait_idle();
    chk("t3_na", qa.size(), 256);
    errs = 0;
    for (int i = 0; i < 256 && i < qa.size(); i++)
      if (qa[i] !== {i[7:0], i[7:0]})
        errs++;
    chk("t3_data", errs, 0);
    chk("t3_b0", qb[0], 16'hFE00);
    chk("t3_b2", qb[2], 16'h0002);
    chk("t3_done", {runs[3:0], done_a, err_a}, 6'b0001_10);

    // stall after one data byte
    go();
    send(8'h02);
    send(8'hAA);
    repeat (15) @(negedge clk);
    chk("t4_pre", {err_a, busy_a}, 2'b01);
    @(negedge clk);
    chk("t4_err", {err_a, halt_a, busy_a}, 3'b111);
    @(negedge clk);
    chk("t4_idle", {err_a, halt_a, busy_a, done_a}, 4'b1000);
    chk("t4_runs", runs, 0);

    // reset in the middle of DATA
    go();
    send(8'h04);
    send(8'h01);
    send(8'h02);
    chk("t5_pre", {wren_a, addr_a, wd_a}, {1'b1, 8'h01, 8'h02});
    clrn = 1'b0;
    #1;
    chk("t5_rst", {9'd0, outs_a()}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    wrs = 0;
    repeat (10) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("t5_nowr", wrs, 0);
    chk("t5_idle", {rdy_a, busy_a, err_a, done_a}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
